// File: rtl/seq_detect_arbiter.sv
// ---------------------------------------------------------------------------
// seq_detect_arbiter
//
// One programmable serial-pattern detector shared by NUM_REQ requesters.
// A round-robin arbiter hands the detector to one requester at a time. The
// controller latches that requester's WIDTH-bit pattern, scans WINDOW valid
// bits of its serial stream, counts overlapping matches, and reports the
// result with a one-cycle done pulse.
//
// Ports
//   clk          clock, rising edge
//   resetn       asynchronous, active-low reset
//   req          per-requester job request (level, held for the job)
//   pattern      requester i's pattern at [i*WIDTH +: WIDTH]
//   din          per-requester serial data bit
//   din_valid    per-requester qualifier for din
//   grant        one-hot detector owner, zero when free
//   busy         high while loading or scanning
//   seen         live hit: shift register equals the target pattern
//   done         one-cycle job-complete pulse
//   done_id      index of the finished requester (held)
//   match_count  matches in the last job (held until next load)
//   aborted      last job ended because req dropped (held)
// ---------------------------------------------------------------------------
module seq_detect_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 5,
  parameter int WINDOW  = 16,
  parameter int CNT_W   = 5,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] pattern,
  input  logic [NUM_REQ-1:0]       din,
  input  logic [NUM_REQ-1:0]       din_valid,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic                     seen,
  output logic                     done,
  output logic [ID_W-1:0]          done_id,
  output logic [CNT_W-1:0]         match_count,
  output logic                     aborted
);

  localparam int FILL_W = $clog2(WIDTH + 1);
  localparam int BIT_W  = $clog2(WINDOW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   ptr;     // last requester served
  logic [ID_W-1:0]   gidx;    // current owner index
  logic [WIDTH-1:0]  target;
  logic [WIDTH-1:0]  shreg;
  logic [FILL_W-1:0] fill;    // valid bits in shreg, saturates at WIDTH
  logic [BIT_W-1:0]  bitcnt;  // bits accepted in this job

  // -------------------------------------------------------------------------
  // Round-robin pick: lowest requesting index above ptr, else lowest at or
  // below ptr. The second loop overrides the first, giving the wrap order.
  // -------------------------------------------------------------------------
  logic            sel_valid;
  logic [ID_W-1:0] sel_idx;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i] && (ID_W'(i) <= ptr)) begin
        sel_valid = 1'b1;
        sel_idx   = ID_W'(i);
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i] && (ID_W'(i) > ptr)) begin
        sel_valid = 1'b1;
        sel_idx   = ID_W'(i);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Detector datapath. A hit is judged on the post-shift value, so the fill
  // test uses the pre-increment count (WIDTH-1 or more means full after it).
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] shift_next;
  logic             hit_next;
  logic             last_bit;

  assign shift_next = {shreg[WIDTH-2:0], din[gidx]};
  assign hit_next   = (shift_next == target) && (fill >= FILL_W'(WIDTH - 1));
  assign last_bit   = (bitcnt == BIT_W'(WINDOW - 1));

  assign seen = (state == RUN) && (shreg == target) && (fill == FILL_W'(WIDTH));

  // -------------------------------------------------------------------------
  // Controller
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: target and shreg are plain registers, not a memory array, so
      // they share the async reset and never show stale data after reset.
      state       <= IDLE;
      ptr         <= ID_W'(NUM_REQ - 1);
      gidx        <= '0;
      grant       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      done_id     <= '0;
      match_count <= '0;
      aborted     <= 1'b0;
      target      <= '0;
      shreg       <= '0;
      fill        <= '0;
      bitcnt      <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register in this
      // block sees the values from before the edge regardless of order.
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sel_valid) begin
            gidx  <= sel_idx;
            grant <= NUM_REQ'(1) << sel_idx;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end

        LOAD: begin
          target      <= pattern[gidx*WIDTH +: WIDTH];
          shreg       <= '0;
          fill        <= '0;
          bitcnt      <= '0;
          match_count <= '0;
          aborted     <= 1'b0;
          state       <= RUN;
        end

        RUN: begin
          if (!req[gidx]) begin
            // Owner withdrew: finish now, the bit on this edge is dropped.
            aborted <= 1'b1;
            grant   <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            done_id <= gidx;
            state   <= DONE;
          end else if (din_valid[gidx]) begin
            shreg  <= shift_next;
            bitcnt <= bitcnt + 1'b1;
            if (fill != FILL_W'(WIDTH))
              fill <= fill + 1'b1;
            if (hit_next && (match_count != '1))
              match_count <= match_count + 1'b1;
            if (last_bit) begin
              grant   <= '0;
              busy    <= 1'b0;
              done    <= 1'b1;
              done_id <= gidx;
              state   <= DONE;
            end
          end
        end

        DONE: begin
          ptr   <= gidx;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// ---------------------------------------------------------------------------
// tb_seq_detect_arbiter
//
// Self-checking bench for seq_detect_arbiter. A job-level reference model
// keeps the owner, the latched pattern and the list of accepted bits; the
// expected outputs are derived from that history every cycle. Directed jobs
// pin the model with hand-computed values, then randomized traffic runs.
// ---------------------------------------------------------------------------
module tb_seq_detect_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 5;
  localparam int WINDOW  = 16;
  localparam int CNT_W   = 5;
  localparam int ID_W    = 2;

  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_RUN  = 2;
  localparam int P_DONE = 3;

  logic                     clk    = 1'b0;
  logic                     resetn = 1'b0;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] pattern;
  logic [NUM_REQ-1:0]       din;
  logic [NUM_REQ-1:0]       din_valid;
  logic [NUM_REQ-1:0]       grant;
  logic                     busy;
  logic                     seen;
  logic                     done;
  logic [ID_W-1:0]          done_id;
  logic [CNT_W-1:0]         match_count;
  logic                     aborted;

  seq_detect_arbiter #(
    .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .WINDOW(WINDOW), .CNT_W(CNT_W), .ID_W(ID_W)
  ) dut (
    .clk(clk), .resetn(resetn), .req(req), .pattern(pattern), .din(din),
    .din_valid(din_valid), .grant(grant), .busy(busy), .seen(seen),
    .done(done), .done_id(done_id), .match_count(match_count), .aborted(aborted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int seen_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  int               m_phase   = P_IDLE;
  int               m_ptr     = NUM_REQ - 1;
  int               m_owner   = 0;
  int               m_done_id = 0;
  logic [WIDTH-1:0] m_pat     = '0;
  bit               m_ab      = 1'b0;
  bit               m_found;
  bit               m_bits[$];

  // Value of the WIDTH bits ending at position endn (exclusive), oldest bit
  // landing in the MSB.
  function automatic logic [WIDTH-1:0] tail_val(input int endn);
    logic [WIDTH-1:0] v = '0;
    for (int j = endn - WIDTH; j < endn; j++) v = {v[WIDTH-2:0], m_bits[j]};
    return v;
  endfunction

  function automatic int exp_count();
    int c = 0;
    for (int n = WIDTH; n <= m_bits.size(); n++)
      if (tail_val(n) == m_pat) c++;
    if (c > (1 << CNT_W) - 1) c = (1 << CNT_W) - 1;
    return c;
  endfunction

  function automatic logic exp_seen();
    if (m_phase != P_RUN || m_bits.size() < WIDTH) return 1'b0;
    return tail_val(m_bits.size()) == m_pat;
  endfunction

  function automatic logic [NUM_REQ-1:0] exp_grant();
    logic [NUM_REQ-1:0] g = '0;
    if (m_phase == P_LOAD || m_phase == P_RUN) g[m_owner] = 1'b1;
    return g;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        m_phase = P_IDLE; m_ptr = NUM_REQ - 1; m_owner = 0; m_done_id = 0;
        m_pat = '0; m_ab = 1'b0; m_bits.delete();
      end else begin
        case (m_phase)
          P_IDLE: if (req != '0) begin
            m_found = 1'b0;
            for (int off = 1; off <= NUM_REQ; off++)
              if (!m_found && req[(m_ptr + off) % NUM_REQ]) begin
                m_found = 1'b1;
                m_owner = (m_ptr + off) % NUM_REQ;
              end
            m_phase = P_LOAD;
          end
          P_LOAD: begin
            m_pat = pattern[m_owner*WIDTH +: WIDTH];
            m_bits.delete();
            m_ab = 1'b0;
            m_phase = P_RUN;
          end
          P_RUN: begin
            if (!req[m_owner]) begin
              m_ab = 1'b1; m_done_id = m_owner; m_phase = P_DONE;
            end else if (din_valid[m_owner]) begin
              m_bits.push_back(din[m_owner]);
              if (m_bits.size() == WINDOW) begin
                m_done_id = m_owner; m_phase = P_DONE;
              end
            end
          end
          default: begin
            m_ptr = m_owner; m_phase = P_IDLE;
          end
        endcase
      end
    end
  end

  // Compare process: every cycle, on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      check("grant", grant, exp_grant());
      check("busy", busy, (m_phase == P_LOAD || m_phase == P_RUN));
      check("seen", seen, exp_seen());
      check("done", done, (m_phase == P_DONE));
      check("done_id", done_id, m_done_id);
      check("match_count", match_count, exp_count());
      check("aborted", aborted, m_ab);
      if (seen) seen_cnt++;
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the rising edge)
  // -------------------------------------------------------------------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    while (grant == '0 && n < 100) begin
      cycle();
      din = NUM_REQ'($urandom);
      n++;
    end
    check("grant_timeout", (n >= 100), 0);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin
      cycle();
      din = NUM_REQ'($urandom);
      n++;
    end
    check("done_timeout", (n >= 100), 0);
  endtask

  task automatic start_job(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ-1:0] exp_g);
    req = r;
    cycle();
    check("start_grant", grant, exp_g);
    cycle();
  endtask

  // Present n bits to requester idx, first bit = bits[n-1]. With gaps, each
  // bit is preceded by one invalid cycle. Other requesters see random noise.
  task automatic feed(input int idx, input logic [31:0] bits, input int n, input bit gaps,
                      output int cyc, output logic [31:0] seen_v);
    cyc = 0;
    seen_v = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (gaps) begin
        din_valid = NUM_REQ'($urandom);
        din_valid[idx] = 1'b0;
        din = NUM_REQ'($urandom);
        cycle();
        cyc++;
      end
      din_valid = NUM_REQ'($urandom);
      din_valid[idx] = 1'b1;
      din = NUM_REQ'($urandom);
      din[idx] = bits[i];
      cycle();
      cyc++;
      seen_v = {seen_v[30:0], seen};
    end
    din_valid = '0;
  endtask

  // -------------------------------------------------------------------------
  // Test sequence
  // -------------------------------------------------------------------------
  int          n, cyc;
  logic [31:0] sv;

  initial begin
    req = '0; pattern = '0; din = '0; din_valid = '0;
    repeat (3) cycle();
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", match_count, 0);
    resetn = 1'b1;
    cycle();

    // Round-robin fairness: 0,1,2,3,0 with a 2-cycle done-to-grant gap.
    req = '1;
    din_valid = '1;
    for (int j = 0; j < 5; j++) begin
      wait_grant(n);
      check("rr_grant", grant, 1 << (j % NUM_REQ));
      if (j > 0) check("rr_gap", n, 2);
      wait_done(n);
    end
    cycle();
    req = '0;
    din_valid = '0;
    cycle();

    // Overlapping matches on requester 0.
    pattern[0*WIDTH +: WIDTH] = 5'b10101;
    start_job(4'b0001, 4'b0001);
    seen_cnt = 0;
    feed(0, 32'b1010101000000000, 16, 1'b0, cyc, sv);
    wait_done(n);
    check("ovl_done_lat", n, 0);
    check("ovl_id", done_id, 0);
    check("ovl_count", match_count, 2);
    check("ovl_abort", aborted, 0);
    check("ovl_seen_trace", sv[15:0], 16'h0A00);
    check("ovl_seen_cycles", seen_cnt, 2);
    cycle();
    req = '0;

    // Valid gaps: 16 ones every other cycle on requester 1.
    pattern[1*WIDTH +: WIDTH] = 5'b11111;
    start_job(4'b0010, 4'b0010);
    feed(1, 32'hFFFF, 16, 1'b1, cyc, sv);
    wait_done(n);
    check("gap_latency", cyc + n, 32);
    check("gap_count", match_count, 12);
    check("gap_id", done_id, 1);
    cycle();
    req = '0;

    // Late pattern change: 11011 latched, switched to 00100 after 2 bits.
    pattern[1*WIDTH +: WIDTH] = 5'b11011;
    start_job(4'b0010, 4'b0010);
    feed(1, 32'b11, 2, 1'b0, cyc, sv);
    pattern[1*WIDTH +: WIDTH] = 5'b00100;
    feed(1, 32'b01101101100000, 14, 1'b0, cyc, sv);
    wait_done(n);
    check("late_count", match_count, 3);
    cycle();
    req = '0;

    // Abort: requester 2 drops after 7 zero bits; 0 and 3 also request.
    pattern[2*WIDTH +: WIDTH] = 5'b00000;
    start_job(4'b1101, 4'b0100);
    feed(2, 32'h0, 7, 1'b0, cyc, sv);
    req[2] = 1'b0;
    din_valid[2] = 1'b1;
    din[2] = 1'b0;
    cycle();
    din_valid = '0;
    check("abort_done", done, 1);
    check("abort_id", done_id, 2);
    check("abort_flag", aborted, 1);
    check("abort_count", match_count, 3);
    wait_grant(n);
    check("abort_next_grant", grant, 4'b1000);
    din_valid = '1;
    wait_done(n);
    cycle();
    req = '0;
    din_valid = '0;
    repeat (2) cycle();

    // Randomized traffic.
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 29) == 0) req = NUM_REQ'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 3))
          0: pattern[$urandom_range(0, NUM_REQ-1)*WIDTH +: WIDTH] = 5'b10101;
          1: pattern[$urandom_range(0, NUM_REQ-1)*WIDTH +: WIDTH] = 5'b11111;
          2: pattern[$urandom_range(0, NUM_REQ-1)*WIDTH +: WIDTH] = 5'b00000;
          default: pattern[$urandom_range(0, NUM_REQ-1)*WIDTH +: WIDTH] = WIDTH'($urandom);
        endcase
      end
      din = NUM_REQ'($urandom);
      for (int i = 0; i < NUM_REQ; i++) din_valid[i] = ($urandom_range(0, 3) != 0);
      cycle();
    end
    req = '0;
    din_valid = '0;
    repeat (4) cycle();

    // Reset in the middle of a job.
    req = '1;
    din_valid = '1;
    wait_grant(n);
    repeat (5) cycle();
    #2;
    resetn = 1'b0;
    #1;
    check("rstmid_grant", grant, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_seen", seen, 0);
    check("rstmid_done", done, 0);
    repeat (2) cycle();
    resetn = 1'b1;
    wait_grant(n);
    check("rstmid_first_grant", grant, 4'b0001);
    wait_done(n);
    cycle();
    req = '0;
    din_valid = '0;
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_arbiter.md
# seq_detect_arbiter

Shares one programmable serial-pattern detector between `NUM_REQ` requesters. Each requester submits a `WIDTH`-bit target pattern and a serial bit stream. A round-robin arbiter grants the detector to one requester at a time. The controller loads that requester's pattern, scans `WINDOW` valid bits of its stream, counts overlapping matches, and reports the result with a one-cycle `done` pulse. It sits between the per-channel serial front ends and the status/interrupt logic.

## Interface
- `NUM_REQ`, 4: number of requesters (≥2).
- `WIDTH`, 5: pattern length in bits.
- `WINDOW`, 16: valid bits scanned per job.
- `CNT_W`, 5: width of `match_count`.
- `ID_W`, 2: width of `done_id`; equals $clog2(NUM_REQ).
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `req`  in  NUM_REQ  per-requester job request; level, held for the whole job.
- `pattern`  in  NUM_REQ*WIDTH  requester i's pattern at `[i*WIDTH +: WIDTH]`.
- `din`  in  NUM_REQ  per-requester serial data bit.
- `din_valid`  in  NUM_REQ  per-requester qualifier for `din`.
- `grant`  out  NUM_REQ  one-hot owner of the detector; all-zero when free.
- `busy`  out  1  high in LOAD and RUN.
- `seen`  out  1  live detector hit for the granted stream.
- `done`  out  1  one-cycle job-complete pulse.
- `done_id`  out  ID_W  index of the finished requester; valid with `done`, held after.
- `match_count`  out  CNT_W  matches in the last job; held until the next LOAD.
- `aborted`  out  1  job ended early because `req` dropped; held with `match_count`.

## Operation
- The FSM has four states: IDLE, LOAD, RUN, DONE. Reset puts it in IDLE.
- On reset, every output is 0. The round-robin pointer is set to `NUM_REQ-1`, so requester 0 has first priority.
- **IDLE**
  - If any `req` bit is set, select the first requester at or after pointer+1, with wrap-around.
  - Register its one-hot `grant` and go to LOAD.
- **LOAD** (one cycle)
  - Latch the granted `pattern` slice into `target`.
  - Clear the shift register, the fill counter (saturates at `WIDTH`), the bit counter, `match_count`, and `aborted`.
  - Ignore `din_valid` in this state. Go to RUN.
- **RUN**
  - On each edge where `din_valid[g]` is high, shift `din[g]` into the LSB of the shift register. The first-received bit aligns with `target[WIDTH-1]`.
  - On the same edge, increment the fill counter and the bit counter.
  - If the post-shift contents equal `target` and fill is `WIDTH`, increment `match_count`, saturating at all-ones. Overlapping matches all count.
  - `seen` = (shift == `target`) && (fill == `WIDTH`) && RUN. It is decoded from registers.
  - Go to DONE on the edge that accepts the `WINDOW`-th valid bit.
  - If `req[g]` is sampled low in RUN, go to DONE with `aborted`=1. A bit valid on that edge is not accepted.
  - Changes to `pattern[g]` after LOAD have no effect.
- **DONE** (one cycle)
  - `done`=1, `done_id`=g, `grant`=0, `busy`=0.
  - The pointer is set to g. Go to IDLE.
- Inputs from non-granted requesters are ignored.
- Clearing `resetn` at any time returns the FSM to IDLE and clears all outputs immediately. A job in progress is lost and produces no `done`.

## Timing
- `req` sampled high at edge k (in IDLE): `grant` and `busy` rise after edge k; the FSM is in LOAD.
- RUN begins after edge k+1. The first bit can be accepted at edge k+2.
- With `din_valid` continuously high, the last bit is taken at edge k+1+`WINDOW`.
- `done` is high in the cycle after edge k+1+`WINDOW`.
- Earliest next grant is after edge k+3+`WINDOW`. There is always one IDLE cycle between jobs.
- `seen` rises in the cycle after the edge that shifts in the completing bit. It stays high only while the register contents still match.
- `match_count` is final when `done` is high.

## Test plan
- **Overlapping matches.** Requester 0, pattern 10101, stream 1010101 followed by 9 zeros, continuous valid. Required: `done`, `done_id`=0, `match_count`=2, `aborted`=0. `seen` is high for exactly 2 cycles, the first in the cycle after the 5th bit.
- **Round-robin fairness.** All four `req` held high with any stream. Required: grant order 0,1,2,3,0. Each `done` is followed by the next `grant` exactly 2 cycles later.
- **Valid gaps.** Pattern 11111, 16 ones delivered with `din_valid` toggling every cycle. Required: `done` 32 cycles after RUN entry, `match_count`=12.
- **Abort.** Drop `req[2]` after 7 accepted bits of a pattern 00000 all-zero stream. Required: `done`, `done_id`=2, `aborted`=1, `match_count`=3. The next grant goes to requester 3 if it is requesting.
- **Late pattern change.** Requester 1's `pattern` is changed during RUN. Required: the count reflects the pattern latched at LOAD.
- **Reset mid-operation.** Assert `resetn`=0 asynchronously mid-RUN. Required: `grant`, `busy`, `seen` go to 0 immediately with no `done`. After release, requester 0 wins when all request.
